// File: rtl/window_adder_if.sv
// Operand/result stream bundle for window_adder: operand pair in, window total out.
// The master side supplies operands and consumes results; the slave side is the adder.
interface window_adder_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SUM_W = WIDTH + 1 + $clog2(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             out_full;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_full
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_full
    );
endinterface

// File: rtl/window_adder.sv
// Streaming a+b adder reporting the total of the last DEPTH sums via a valid/ready register.
// Define WINDOW_ADDER_MEAN_EN to report the window total divided by DEPTH instead.
module window_adder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    window_adder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int S_W   = WIDTH + 1;
    localparam int SUM_W = WIDTH + 1 + PTR_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [S_W-1:0]   buf_mem [DEPTH];
    logic [SUM_W-1:0] running;
    logic [PTR_W-1:0] wp;
    logic [PTR_W:0]   count;

    logic [SUM_W-1:0] out_sum_q;
    logic             out_valid_q;
    logic             out_full_q;

    logic             accept;
    logic [S_W-1:0]   s;
    logic [SUM_W-1:0] running_nxt;
    logic [PTR_W:0]   count_nxt;
    logic [SUM_W-1:0] result;

    // clear blocks acceptance outright so a flush never races a new sample.
    assign bus.in_ready = !clear && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign s           = S_W'(bus.in_a) + S_W'(bus.in_b);
    // The evicted slot is zero until first written, so partial windows need no special case.
    assign running_nxt = running + SUM_W'(s) - SUM_W'(buf_mem[wp]);
    assign count_nxt   = (count == FULL_CNT) ? count : count + 1'b1;

`ifdef WINDOW_ADDER_MEAN_EN
    assign result = running_nxt >> PTR_W;
`else
    assign result = running_nxt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the window memory is reset because partial-window totals rely on unwritten slots reading zero.
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
            running     <= '0;
            wp          <= '0;
            count       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_full_q  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
            running     <= '0;
            wp          <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            buf_mem[wp] <= s;
            running     <= running_nxt;
            wp          <= wp + 1'b1;
            count       <= count_nxt;
            out_sum_q   <= result;
            out_full_q  <= (count_nxt == FULL_CNT);
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_full  = out_full_q;
endmodule

// File: tb/tb_window_adder.sv
// Self-checking bench for window_adder: directed plan steps then random traffic,
// all compared against a queue-based window model.
module tb_window_adder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    window_adder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    window_adder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the last DEPTH sums kept as a plain queue.
    int win[$];
    bit exp_valid;
    int exp_sum;
    bit exp_full;

    task automatic model_reset();
        win.delete();
        exp_valid = 0;
        exp_sum   = 0;
        exp_full  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check in_ready before the
    // rising edge, advance the model on the edge, check outputs 1 time unit later.
    task automatic cycle(input bit v, input int a, input int b, input bit ordy, input bit clr);
        bit exp_rdy;
        bit acc;
        int total;
        bus.in_valid  = v;
        bus.in_a      = WIDTH'(a);
        bus.in_b      = WIDTH'(b);
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        exp_rdy = !clr && (!exp_valid || ordy);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        if (clr) begin
            win.delete();
            exp_valid = 0;
        end else if (acc) begin
            win.push_back(a + b);
            if (win.size() > DEPTH) void'(win.pop_front());
            total = 0;
            foreach (win[i]) total += win[i];
`ifdef WINDOW_ADDER_MEAN_EN
            exp_sum = total / DEPTH;
`else
            exp_sum = total;
`endif
            exp_full  = (win.size() == DEPTH);
            exp_valid = 1;
        end else if (exp_valid && ordy) begin
            exp_valid = 0;
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("out_sum",   32'(bus.out_sum),   32'(exp_sum));
        check("out_full",  32'(bus.out_full),  32'(exp_full));
        @(negedge clk);
    endtask

    initial begin
        int fill_exp[5];
        int max_exp[4];
        fill_exp = '{10, 30, 60, 100, 140};
`ifdef WINDOW_ADDER_MEAN_EN
        max_exp = '{127, 255, 382, 510};
`else
        max_exp = '{510, 1020, 1530, 2040};
`endif
        rst           = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #2;
        check("reset_valid", 32'(bus.out_valid), 0);
        check("reset_sum",   32'(bus.out_sum),   0);
        check("reset_full",  32'(bus.out_full),  0);
        check("reset_ready", 32'(bus.in_ready),  1);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulsed mid-stream, then the first sample after release.
        cycle(1, 20, 30, 1, 0);
        cycle(1, 1, 2, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_sum",   32'(bus.out_sum),   0);
        check("midrst_full",  32'(bus.out_full),  0);
        check("midrst_ready", 32'(bus.in_ready),  1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 3, 4, 1, 0);
        check("rst_first_sum", 32'(bus.out_sum), 7);

        // Fill and wrap with back-to-back samples.
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 10 * (i + 1) - 3, 3, 1, 0);
            check("fill_sum",  32'(bus.out_sum),  32'(fill_exp[i]));
            check("fill_full", 32'(bus.out_full), (i >= 3) ? 32'd1 : 32'd0);
        end

        // Maximum operands.
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 255, 255, 1, 0);
            check("max_sum", 32'(bus.out_sum), 32'(max_exp[i]));
        end

        // Backpressure: result held while downstream stalls, pending pair waits.
        cycle(0, 0, 0, 1, 1);
        cycle(1, 3, 4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 9, 9, 0, 0);
            check("stall_sum", 32'(bus.out_sum), 7);
        end
        cycle(1, 9, 9, 1, 0);
        check("stall_release_sum", 32'(bus.out_sum), 25);
        cycle(0, 0, 0, 1, 0);
        check("drain_valid", 32'(bus.out_valid), 0);

        // Clear mid-window with in_valid high.
        cycle(0, 0, 0, 1, 1);
        cycle(1, 5, 5, 1, 0);
        cycle(1, 10, 10, 1, 0);
        cycle(1, 50, 50, 1, 1);
        check("clear_valid", 32'(bus.out_valid), 0);
        cycle(1, 2, 3, 1, 0);
        check("clear_next_sum",  32'(bus.out_sum),  5);
        check("clear_next_full", 32'(bus.out_full), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int ra;
            int rb;
            ra = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, ra, rb,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
